sequenciador_pc: RTL

//  Multicycle fetch/decode sequencer that drives the contador_programa control inputs.
//  - Fetches each instruction from instruction memory over a req/ack handshake.
//  - Decodes MIPS control-flow opcodes and holds execution for a fixed latency.
//  - Issues exactly one pc_control update per instruction, with jump/branch/register targets.
//  - Sits between instruction memory, the ALU zero flag and the program counter.

---
 rtl/sequenciador_pc.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sequenciador_pc.sv
// Multicycle fetch/decode sequencer driving the program-counter control inputs.
// One pc_control update per instruction; fetch timeout leads to a sticky fault.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | imem_req high, waiting for imem_ack (bounded by TIMEOUT)
// DECODE   | one cycle, picks HALT or EXEC
// EXEC     | EXEC_CYCLES cycles, latches alu_zero / rs_data on the last one
// UPDATE   | one cycle, pc_control carries the selected code
// HALT     | halted, waits for start to skip the halt word
// FAULT    | absorbing until reset
module sequenciador_pc #(
  parameter int          EXEC_CYCLES = 1,
  parameter int          TIMEOUT     = 16,
  parameter logic [5:0]  HALT_OP     = 6'b111111
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_alu_zero,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_instr,
  output logic [2:0]  o_pc_control,
  output logic [25:0] o_jump_address,
  output logic [15:0] o_branch_offset,
  output logic [31:0] o_reg_address,
  output logic        o_halted,
  output logic        o_fault,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);
  localparam logic [EW-1:0] EXEC_LOAD = EW'(EXEC_CYCLES - 1);

  state_t        r_state, w_next;
  logic [31:0]   r_instr;
  logic [31:0]   r_reg_address;
  logic          r_zero;
  logic [TW-1:0] r_wait;
  logic [EW-1:0] r_exec;
  logic [5:0]    w_op, w_funct;
  logic [2:0]    w_pc_sel;

  assign w_op    = r_instr[31:26];
  assign w_funct = r_instr[5:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_reg_address <= '0;
      r_zero        <= 1'b0;
      r_wait        <= TO_LOAD;
      r_exec        <= EXEC_LOAD;
    end else begin
      r_state <= w_next;
      // Fetch timer re-arms whenever we are outside FETCH.
      if (r_state != S_FETCH) begin
        r_wait <= TO_LOAD;
      end else if (i_imem_ack) begin
        r_instr <= i_imem_data;
      end else if (r_wait != '0) begin
        r_wait <= r_wait - 1'b1;
      end
      if (r_state == S_DECODE) begin
        r_exec <= EXEC_LOAD;
      end else if (r_state == S_EXEC) begin
        if (r_exec == '0) begin
          r_zero        <= i_alu_zero;
          r_reg_address <= i_rs_data;
        end else begin
          r_exec <= r_exec - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_FETCH;
      S_FETCH: begin
        if (i_imem_ack)        w_next = S_DECODE;
        else if (r_wait == '0) w_next = S_FAULT;
      end
      S_DECODE: w_next = (w_op == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:   if (r_exec == '0) w_next = S_UPDATE;
      S_UPDATE: w_next = S_FETCH;
      S_HALT:   if (i_start) w_next = S_UPDATE;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end

  // The halt word falls through to PC+4, which is exactly the skip we want on restart.
  always_comb begin
    w_pc_sel = 3'b001;
    case (w_op)
      6'b000100: w_pc_sel = r_zero ? 3'b010 : 3'b001;
      6'b000101: w_pc_sel = r_zero ? 3'b001 : 3'b010;
      6'b000010,
      6'b000011: w_pc_sel = 3'b011;
      6'b000000: w_pc_sel = (w_funct == 6'b001000) ? 3'b100 : 3'b001;
      default:   w_pc_sel = 3'b001;
    endcase
  end

  assign o_imem_req      = (r_state == S_FETCH);
  assign o_pc_control    = (r_state == S_UPDATE) ? w_pc_sel : 3'b000;
  assign o_instr         = r_instr;
  assign o_jump_address  = r_instr[25:0];
  assign o_branch_offset = r_instr[15:0];
  assign o_reg_address   = r_reg_address;
  assign o_halted        = (r_state == S_HALT);
  assign o_fault         = (r_state == S_FAULT);
  assign o_state         = r_state;

endmodule
